// File: rtl/fifo_cam_wbuf_if.sv
// fifo_cam_wbuf_if: bus bundle for the CAM write buffer.
// The master modport belongs to the requester (cache write path) and the
// slave modport to the buffer itself. Clock and reset are plain ports.
interface fifo_cam_wbuf_if #(
  parameter int W_KEY         = 32,
  parameter int W_DATA        = 32,
  parameter int C_NUMBERWORDS = 8
);
  localparam int W_BE  = W_DATA / 8;
  localparam int W_CNT = $clog2(C_NUMBERWORDS + 1);

  // push / pop / flush
  logic                     Write_i;
  logic [W_KEY-1:0]         WriteKey_i;
  logic [W_DATA-1:0]        WriteData_i;
  logic [W_BE-1:0]          WriteBe_i;
  logic                     Read_i;
  logic                     Flush_i;

  // head of queue and status
  logic [W_KEY-1:0]         ReadKey_oc;
  logic [W_DATA-1:0]        ReadData_oc;
  logic [W_BE-1:0]          ReadBe_oc;
  logic                     Empty_oc;
  logic                     Full_oc;
  logic [W_CNT-1:0]         Count_oc;

  // associative lookup
  logic                     LookupEn_i;
  logic [W_KEY-1:0]         LookupKey_i;
  logic [W_KEY-1:0]         LookupMask_i;
  logic [C_NUMBERWORDS-1:0] LookupVec_oc;
  logic                     LookupHit_oc;
  logic [W_DATA-1:0]        LookupData_oc;
  logic [W_BE-1:0]          LookupBe_oc;

  modport master (
    output Write_i, WriteKey_i, WriteData_i, WriteBe_i, Read_i, Flush_i,
    output LookupEn_i, LookupKey_i, LookupMask_i,
    input  ReadKey_oc, ReadData_oc, ReadBe_oc, Empty_oc, Full_oc, Count_oc,
    input  LookupVec_oc, LookupHit_oc, LookupData_oc, LookupBe_oc
  );

  modport slave (
    input  Write_i, WriteKey_i, WriteData_i, WriteBe_i, Read_i, Flush_i,
    input  LookupEn_i, LookupKey_i, LookupMask_i,
    output ReadKey_oc, ReadData_oc, ReadBe_oc, Empty_oc, Full_oc, Count_oc,
    output LookupVec_oc, LookupHit_oc, LookupData_oc, LookupBe_oc
  );
endinterface

// File: rtl/fifo_cam_wbuf.sv
// fifo_cam_wbuf: shift-register write buffer with masked associative lookup.
// Slot 0 is the oldest entry and drives the read port; valid slots are
// always contiguous from 0 to Count-1. Lookup returns the youngest match
// for read-after-write forwarding and sees registered state only.
// Optional feature: define FIFO_CAM_WBUF_COALESCE_EN to merge writes whose
// key exactly equals a buffered entry into the youngest such entry.
module fifo_cam_wbuf #(
  parameter int W_KEY         = 32,
  parameter int W_DATA        = 32,
  parameter int C_NUMBERWORDS = 8
) (
  input  logic             sClk_i,
  input  logic             snRst_i,
  fifo_cam_wbuf_if.slave   bus
);
  localparam int W_BE  = W_DATA / 8;
  localparam int W_CNT = $clog2(C_NUMBERWORDS + 1);
  localparam int W_IDX = $clog2(C_NUMBERWORDS);

  // registered state
  logic [W_KEY-1:0]         r_key  [C_NUMBERWORDS];
  logic [W_DATA-1:0]        r_data [C_NUMBERWORDS];
  logic [W_BE-1:0]          r_be   [C_NUMBERWORDS];
  logic [C_NUMBERWORDS-1:0] r_vld;
  logic [W_CNT-1:0]         r_cnt;
  logic                     r_empty;
  logic                     r_full;

  // next-state
  logic [W_KEY-1:0]         w_nkey  [C_NUMBERWORDS];
  logic [W_DATA-1:0]        w_ndata [C_NUMBERWORDS];
  logic [W_BE-1:0]          w_nbe   [C_NUMBERWORDS];
  logic [C_NUMBERWORDS-1:0] w_nvld;
  logic [W_CNT-1:0]         w_ncnt;

  // control
  logic                     w_read_en;
  logic                     w_write_en;
  logic                     w_merge;
  logic [W_IDX-1:0]         w_merge_idx;
  logic [W_IDX-1:0]         w_merge_tgt;
  logic [W_CNT-1:0]         w_app_idx;

  // lookup
  logic [C_NUMBERWORDS-1:0] w_lk_vec;
  logic [W_DATA-1:0]        w_lk_data;
  logic [W_BE-1:0]          w_lk_be;

  assign w_read_en = bus.Read_i & ~r_empty;

`ifdef FIFO_CAM_WBUF_COALESCE_EN
  logic w_merge_hit;

  // Youngest valid entry whose key equals the write key (full-width compare).
  always_comb begin
    w_merge_hit = 1'b0;
    w_merge_idx = '0;
    for (int i = 0; i < C_NUMBERWORDS; i++) begin
      if (r_vld[i] && (r_key[i] == bus.WriteKey_i)) begin
        w_merge_hit = 1'b1;
        w_merge_idx = W_IDX'(i);
      end
    end
  end

  // A match held only by the departing head cannot absorb the write.
  assign w_merge = bus.Write_i & w_merge_hit &
                   ~(w_read_en & (w_merge_idx == '0));
`else
  assign w_merge     = 1'b0;
  assign w_merge_idx = '0;
`endif

  // Appends need a free slot, or one freed by the concurrent pop.
  assign w_write_en  = bus.Write_i & ~w_merge & (~r_full | w_read_en);

  // Targets move down one slot when the queue shifts in the same cycle.
  assign w_merge_tgt = w_read_en ? (w_merge_idx - W_IDX'(1)) : w_merge_idx;
  assign w_app_idx   = w_read_en ? (r_cnt - W_CNT'(1)) : r_cnt;

  // Next-state: flush wins, otherwise shift on pop, then merge or append.
  always_comb begin
    w_nkey  = r_key;
    w_ndata = r_data;
    w_nbe   = r_be;
    w_nvld  = r_vld;
    w_ncnt  = r_cnt;
    if (bus.Flush_i) begin
      w_nvld = '0;
      w_ncnt = '0;
    end else begin
      if (w_read_en) begin
        for (int i = 0; i < C_NUMBERWORDS - 1; i++) begin
          w_nkey[i]  = r_key[i+1];
          w_ndata[i] = r_data[i+1];
          w_nbe[i]   = r_be[i+1];
        end
        w_nvld = {1'b0, r_vld[C_NUMBERWORDS-1:1]};
      end
      if (w_merge) begin
        for (int i = 0; i < C_NUMBERWORDS; i++) begin
          if (W_IDX'(i) == w_merge_tgt) begin
            for (int b = 0; b < W_BE; b++) begin
              if (bus.WriteBe_i[b]) begin
                w_ndata[i][b*8 +: 8] = bus.WriteData_i[b*8 +: 8];
              end
            end
            w_nbe[i] = w_nbe[i] | bus.WriteBe_i;
          end
        end
      end
      if (w_write_en) begin
        for (int i = 0; i < C_NUMBERWORDS; i++) begin
          if (W_CNT'(i) == w_app_idx) begin
            w_nkey[i]  = bus.WriteKey_i;
            w_ndata[i] = bus.WriteData_i;
            w_nbe[i]   = bus.WriteBe_i;
            w_nvld[i]  = 1'b1;
          end
        end
      end
      case ({w_write_en, w_read_en})
        2'b10:   w_ncnt = r_cnt + W_CNT'(1);
        2'b01:   w_ncnt = r_cnt - W_CNT'(1);
        default: w_ncnt = r_cnt;
      endcase
    end
  end

  // State register; reset empties the buffer and clears storage at once.
  always_ff @(posedge sClk_i or negedge snRst_i) begin
    if (!snRst_i) begin
      for (int i = 0; i < C_NUMBERWORDS; i++) begin
        r_key[i]  <= '0;
        r_data[i] <= '0;
        r_be[i]   <= '0;
      end
      r_vld   <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_key   <= w_nkey;
      r_data  <= w_ndata;
      r_be    <= w_nbe;
      r_vld   <= w_nvld;
      r_cnt   <= w_ncnt;
      r_empty <= (w_ncnt == '0);
      r_full  <= (w_ncnt == W_CNT'(C_NUMBERWORDS));
    end
  end

  // Masked compare per slot; the highest-index hit (youngest) is forwarded.
  always_comb begin
    w_lk_vec  = '0;
    w_lk_data = '0;
    w_lk_be   = '0;
    for (int i = 0; i < C_NUMBERWORDS; i++) begin
      if (bus.LookupEn_i && r_vld[i] &&
          (((r_key[i] ^ bus.LookupKey_i) & bus.LookupMask_i) == '0)) begin
        w_lk_vec[i] = 1'b1;
        w_lk_data   = r_data[i];
        w_lk_be     = r_be[i];
      end
    end
  end

  assign bus.ReadKey_oc    = r_vld[0] ? r_key[0]  : '0;
  assign bus.ReadData_oc   = r_vld[0] ? r_data[0] : '0;
  assign bus.ReadBe_oc     = r_vld[0] ? r_be[0]   : '0;
  assign bus.Empty_oc      = r_empty;
  assign bus.Full_oc       = r_full;
  assign bus.Count_oc      = r_cnt;
  assign bus.LookupVec_oc  = w_lk_vec;
  assign bus.LookupHit_oc  = |w_lk_vec;
  assign bus.LookupData_oc = w_lk_data;
  assign bus.LookupBe_oc   = w_lk_be;

endmodule
